// File: rtl/adc_mux_emu.sv
// adc_mux_emu: 8-channel SAR ADC emulation for the trackstick positions.
// Optional centre dead-zone on the sampled value: define ADC_DEADZONE_EN.
module adc_mux_emu #(
  parameter int CONV_CYC = 96,
  parameter int NCH      = 4,
  parameter int DZ       = 6
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [7:0] CH0,
  input  logic [7:0] CH1,
  input  logic [7:0] CH2,
  input  logic [7:0] CH3,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  input  logic [2:0] ADDR,
  output logic [7:0] DOUT,
  output logic       EOC,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  localparam logic [9:0] CNT_INIT = 10'(CONV_CYC - 2);
  localparam logic signed [8:0] DZ_S = 9'(DZ);

  state_t     state;
  logic       wr_hist;
  logic       start;
  logic [2:0] addr_q;
  logic [9:0] cnt;
  logic [7:0] hold;
  logic [7:0] result;
  logic [7:0] raw;
  logic [7:0] samp;

  // Snap values within the dead-zone band around centre to 8'h80.
  function automatic logic [7:0] dz_fix(input logic [7:0] v);
    logic signed [8:0] d;
    d = $signed({1'b0, v}) - 9'sd128;
    if (d <= DZ_S && d >= -DZ_S) return 8'h80;
    return v;
  endfunction

  assign start = CS & WR & ~wr_hist;

  // One-cycle history of the write strobe so held strobes start once.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) wr_hist <= 1'b0;
    else        wr_hist <= CS & WR;
  end

  // Channel mux on the latched address; dead channels read full scale.
  always_comb begin
    raw = 8'hFF;
    if (int'(addr_q) < NCH) begin
      unique case (addr_q)
        3'd0:    raw = CH0;
        3'd1:    raw = CH1;
        3'd2:    raw = CH2;
        3'd3:    raw = CH3;
        default: raw = 8'hFF;
      endcase
    end
  end

`ifdef ADC_DEADZONE_EN
  assign samp = dz_fix(raw);
`else
  assign samp = raw;
`endif

  // Conversion FSM; a start edge in any state (re)enters SAMPLE.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      EOC    <= 1'b1;
      BUSY   <= 1'b0;
      result <= 8'h80;
      addr_q <= 3'd0;
      cnt    <= 10'd0;
      hold   <= 8'h80;
    end else if (start) begin
      addr_q <= ADDR;
      state  <= SAMPLE;
      EOC    <= 1'b0;
      BUSY   <= 1'b1;
    end else begin
      unique case (state)
        SAMPLE: begin
          hold  <= samp;
          cnt   <= CNT_INIT;
          state <= CONVERT;
        end
        CONVERT: begin
          if (cnt == 10'd0) begin
            result <= hold;
            state  <= DONE;
            EOC    <= 1'b1;
            BUSY   <= 1'b0;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered read port; idles at zero when not selected.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET)        DOUT <= 8'h00;
    else if (CS && RD) DOUT <= result;
    else               DOUT <= 8'h00;
  end

endmodule

// File: tb/tb_adc_mux_emu.sv
// tb_adc_mux_emu: directed bench for adc_mux_emu.
// Latency, restart, bad channel, async reset and dead-zone cases.
`timescale 1ns/1ps
module tb_adc_mux_emu;

  localparam int C = 96;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic [7:0] CH0, CH1, CH2, CH3;
  logic       CS, WR, RD;
  logic [2:0] ADDR;
  logic [7:0] DOUT;
  logic       EOC, BUSY;

  int checks = 0;
  int errors = 0;

  adc_mux_emu #(.CONV_CYC(C), .NCH(4), .DZ(6)) dut (
    .MCLK (MCLK),
    .RESET(RESET),
    .CH0  (CH0),
    .CH1  (CH1),
    .CH2  (CH2),
    .CH3  (CH3),
    .CS   (CS),
    .WR   (WR),
    .RD   (RD),
    .ADDR (ADDR),
    .DOUT (DOUT),
    .EOC  (EOC),
    .BUSY (BUSY)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge MCLK);
    #1;
  endtask

  task automatic start(input logic [2:0] a);
    CS = 1'b1; WR = 1'b1; ADDR = a;
    tick();
    CS = 1'b0; WR = 1'b0;
  endtask

  task automatic wait_eoc(output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (EOC === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    CS = 1'b1; RD = 1'b1;
    tick();
    check(tag, DOUT, exp);
    CS = 1'b0; RD = 1'b0;
    tick();
    check({tag, "_idle"}, DOUT, 8'h00);
  endtask

  task automatic do_reset;
    RESET = 1'b0;
    #3;
    @(negedge MCLK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic conv(input string tag, input logic [2:0] a,
                      input logic [7:0] exp);
    int n;
    start(a);
    wait_eoc(n);
    check({tag, "_lat"}, n, C);
    rd(tag, exp);
  endtask

  initial begin
    int n;
    int fall;
    int rebusy;
    RESET = 1'b0;
    CS = 0; WR = 0; RD = 0; ADDR = 0;
    CH0 = 8'h10; CH1 = 8'hE0; CH2 = 8'h37; CH3 = 8'h55;
    #12;
    check("rst_eoc", EOC, 1);
    check("rst_busy", BUSY, 0);
    check("rst_dout", DOUT, 8'h00);
    @(negedge MCLK);
    RESET = 1'b1;
    tick();
    rd("rst_read", 8'h80);
    check("idle_eoc", EOC, 1);
    check("idle_busy", BUSY, 0);

    // Latency and sample isolation on CH2.
    CH2 = 8'h37;
    start(3'd2);
    check("t2_eoc_fall", EOC, 0);
    check("t2_busy", BUSY, 1);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (i == 3) CH2 = 8'h99;
      if (EOC === 1'b1) begin
        n = i;
        break;
      end
    end
    check("t2_lat", n, C);
    check("t2_busy_off", BUSY, 0);
    rd("t2_read", 8'h37);

    // Restart mid-conversion, read during CONVERT.
    do_reset();
    CH0 = 8'h10; CH1 = 8'hE0;
    start(3'd0);
    repeat (19) tick();
    CS = 1'b1; RD = 1'b1;
    tick();
    check("t3_rd_conv", DOUT, 8'h80);
    check("t3_eoc_conv", EOC, 0);
    CS = 1'b0; RD = 1'b0;
    repeat (19) tick();
    start(3'd1);
    check("t3_restart_eoc", EOC, 0);
    wait_eoc(n);
    check("t3_lat", n, C);
    rd("t3_read", 8'hE0);

    // Dead channel with level-held write strobe.
    CS = 1'b1; WR = 1'b1; ADDR = 3'd5;
    tick();
    check("t4_busy", BUSY, 1);
    fall = -1;
    rebusy = 0;
    for (int i = 1; i < 200; i++) begin
      tick();
      if (fall < 0 && BUSY === 1'b0) fall = i;
      else if (fall >= 0 && BUSY === 1'b1) rebusy++;
    end
    check("t4_fall", fall, C);
    check("t4_once", rebusy, 0);
    CS = 1'b0; WR = 1'b0;
    tick();
    rd("t4_read", 8'hFF);

    // Async reset in the middle of a conversion.
    CH3 = 8'h55;
    start(3'd3);
    repeat (10) tick();
    CS = 1'b1; RD = 1'b1;
    tick();
    check("t5_pre_dout", DOUT, 8'hFF);
    check("t5_pre_busy", BUSY, 1);
    #2 RESET = 1'b0;
    #1;
    check("t5_eoc", EOC, 1);
    check("t5_busy", BUSY, 0);
    check("t5_dout", DOUT, 8'h00);
    CS = 1'b0; RD = 1'b0;
    @(negedge MCLK);
    RESET = 1'b1;
    tick();
    rd("t5_read", 8'h80);

    // Dead-zone boundaries.
`ifdef ADC_DEADZONE_EN
    CH0 = 8'h85; conv("dz_85", 3'd0, 8'h80);
    CH0 = 8'h86; conv("dz_86", 3'd0, 8'h80);
    CH0 = 8'h87; conv("dz_87", 3'd0, 8'h87);
    CH0 = 8'h7A; conv("dz_7a", 3'd0, 8'h80);
    CH0 = 8'h79; conv("dz_79", 3'd0, 8'h79);
`else
    CH0 = 8'h85; conv("nodz_85", 3'd0, 8'h85);
    CH0 = 8'h7A; conv("nodz_7a", 3'd0, 8'h7A);
    CH0 = 8'h80; conv("nodz_80", 3'd0, 8'h80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_mux_emu.md
Name: adc_mux_emu

Overview:
- Emulates the 8-channel successive-approximation ADC that the Food Fight CPU uses to read the trackstick positions.
- Sits directly downstream of the pseudo-analog stick generators and the analog-joystick remap. It consumes the four 8-bit positions AX0/AY0/AX1/AY1 and serves them to the 68000 bus inside the game core through a start/EOC/read handshake with realistic conversion latency.

Parameters:
- CONV_CYC, 96, MCLK cycles per conversion (start to EOC rising); legal range 4..1023.
- NCH, 4, number of live channels. Channel indices at or above NCH convert to 8'hFF.
- DZ, 6, half-width of the centre dead-zone (used only with the optional feature).

Ports:
- MCLK  in  1  system clock, 48 MHz.
- RESET  in  1  asynchronous, active-low reset.
- CH0  in  8  channel 0 input (AX0).
- CH1  in  8  channel 1 input (AY0).
- CH2  in  8  channel 2 input (AX1).
- CH3  in  8  channel 3 input (AY1).
- CS  in  1  ADC chip select from the core address decode.
- WR  in  1  write strobe; with CS, starts a conversion.
- RD  in  1  read strobe; with CS, drives DOUT.
- ADDR  in  3  channel select, latched on start.
- DOUT  out  8  conversion result. Result register is valid when RD&CS, 8'h00 otherwise.
- EOC  out  1  end of conversion. High when idle or done, low while converting.
- BUSY  out  1  high while in SAMPLE or CONVERT, for debug and OSD.

Behaviour:
- Reset (RESET=0, async): state=IDLE, EOC=1, BUSY=0, result=8'h80, latched channel=0, counter=0, DOUT=0.
- Start event = rising edge of (CS&WR), detected with a 1-cycle registered history. Level-held strobes start only once.
- States:
  - IDLE: EOC=1. On start, latch ADDR, go to SAMPLE.
  - SAMPLE: 1 cycle. Snapshot the selected CHn (or 8'hFF if ADDR>=NCH) into the hold register. Counter=CONV_CYC-2. Go to CONVERT.
  - CONVERT: EOC=0, BUSY=1. Counter decrements each cycle. At 0, copy the hold register to result and go to DONE.
  - DONE: EOC=1, BUSY=0. Identical to IDLE except it records that a result exists. A start goes to SAMPLE.
- Latency: EOC rises exactly CONV_CYC cycles after the cycle in which the start edge is registered.
- EOC falls on the first cycle of SAMPLE (1 cycle after the start edge).
- Changes on CHn after SAMPLE do not affect the in-flight conversion.
- Restart: a start edge during SAMPLE or CONVERT aborts the conversion, latches the new ADDR, and re-enters SAMPLE. The result register keeps its previous value. The full CONV_CYC latency restarts.
- Read: DOUT is registered and equals result one cycle after CS&RD is sampled high. DOUT returns to 0 one cycle after CS&RD drops.
  - Reading during CONVERT returns the previous result, not partial data.
- Simultaneous start and read in one cycle: the read returns the old result and the conversion starts normally.
- Result update and read in the same cycle: DOUT shows the old value that cycle and the new value the next cycle.
- Counter width: 10 bits. No wrap is possible within the legal CONV_CYC range.

Optional Feature:
- Macro ADC_DEADZONE_EN.
- When defined: at SAMPLE, any value v with |v-8'h80| <= DZ is replaced by 8'h80. Comparison uses 9-bit signed arithmetic, and values outside the band pass unchanged. This suppresses pseudo-stick decay jitter around centre.
- When undefined: the sample passes unmodified, and DZ is ignored. Logic and timing are otherwise identical.

Test Plan:
- Reset, then read with no conversion: CS&RD -> DOUT=8'h80 after 1 cycle; EOC=1, BUSY=0.
- CH2=8'h37, start with ADDR=2, then change CH2 to 8'h99 three cycles later -> EOC low for exactly CONV_CYC-1 cycles, high at cycle CONV_CYC. Read gives 8'h37.
- Start ADDR=0 (CH0=8'h10). At cycle 40, start again with ADDR=1 (CH1=8'hE0) -> EOC rises CONV_CYC cycles after the second start. Read gives 8'hE0. A read during CONVERT gives the prior result 8'h80.
- Start with ADDR=5 (>=NCH) -> result 8'hFF. Holding CS&WR high for 200 cycles produces only one conversion, with BUSY deasserted after CONV_CYC cycles.
- Assert RESET mid-CONVERT (async, between clock edges) -> EOC=1, BUSY=0, DOUT=0 immediately. A later read returns 8'h80.
- With ADC_DEADZONE_EN and DZ=6: CH0=8'h85 reads 8'h80, CH0=8'h87 reads 8'h87, CH0=8'h7A reads 8'h80. Without the macro, CH0=8'h85 reads 8'h85.
